// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter: buffers one sample and sends a {CTRL_WORD, sample} frame MSB-first on each frame trigger, then pulses ldac low.
// Optional DAC_OFFSET_BINARY_EN: converts two's-complement input to offset-binary at accept.
module dac_serial_tx #(
  parameter int                   DATA_WIDTH  = 12,
  parameter int                   CTRL_BITS   = 4,
  parameter logic [CTRL_BITS-1:0] CTRL_WORD   = '0,
  parameter int                   LDAC_CYCLES = 1
) (
  input  logic                  dacSerialClock,
  input  logic                  reset,
  input  logic                  frameTrigger,
  input  logic [DATA_WIDTH-1:0] sampleData,
  input  logic                  sampleValid,
  output logic                  sampleReady,
  output logic                  dacSync,
  output logic                  dacDataIn,
  output logic                  ldac,
  output logic                  busy,
  output logic                  underrun
);
  localparam int FRAME_BITS = CTRL_BITS + DATA_WIDTH;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int LW = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]   last_sample_q, last_sample_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]           ldac_cnt_q, ldac_cnt_d;
  logic [DATA_WIDTH-1:0]   sample_in;
  logic [DATA_WIDTH-1:0]   payload;

`ifdef DAC_OFFSET_BINARY_EN
  assign sample_in = {~sampleData[DATA_WIDTH-1], sampleData[DATA_WIDTH-2:0]};
`else
  assign sample_in = sampleData;
`endif

  assign sampleReady = !hold_full_q;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    last_sample_d = last_sample_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    ldac_cnt_d    = ldac_cnt_q;
    payload       = last_sample_q;
    underrun      = 1'b0;
    dacSync       = 1'b1;
    dacDataIn     = 1'b0;
    ldac          = 1'b1;
    busy          = 1'b1;

    // An accept in the trigger cycle fills hold for the following frame only.
    if (sampleValid && !hold_full_q) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (frameTrigger) begin
          if (hold_full_q) begin
            payload       = hold_q;
            last_sample_d = hold_q;
            hold_full_d   = 1'b0;
          end else begin
            underrun = 1'b1;
          end
          shreg_d   = {CTRL_WORD, payload};
          bit_cnt_d = BW'(FRAME_BITS - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        dacSync   = 1'b0;
        dacDataIn = shreg_q[FRAME_BITS-1];
        shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
        if (bit_cnt_q == '0) begin
          state_d    = LOAD;
          ldac_cnt_d = LW'(LDAC_CYCLES - 1);
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      LOAD: begin
        ldac = 1'b0;
        if (ldac_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          ldac_cnt_d = ldac_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) underrun = 1'b0;
  end

  always_ff @(posedge dacSerialClock) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      last_sample_q <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      ldac_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      last_sample_q <= last_sample_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      ldac_cnt_q    <= ldac_cnt_d;
    end
  end
endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: frame bits, ldac/busy timing, underrun, handshake, ignored trigger, mid-frame reset.
module tb_dac_serial_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic        frameTrigger;
  logic [11:0] sampleData;
  logic        sampleValid;
  logic        sampleReady, dacSync, dacDataIn, ldac, busy, underrun;

  int n_vec = 0;
  int n_err = 0;

  dac_serial_tx dut (
    .dacSerialClock(clk),
    .reset(reset),
    .frameTrigger(frameTrigger),
    .sampleData(sampleData),
    .sampleValid(sampleValid),
    .sampleReady(sampleReady),
    .dacSync(dacSync),
    .dacDataIn(dacDataIn),
    .ldac(ldac),
    .busy(busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_code(input logic [11:0] x);
`ifdef DAC_OFFSET_BINARY_EN
    return {~x[11], x[10:0]};
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_sample(input logic [11:0] x);
    sampleValid = 1'b1;
    sampleData  = x;
    tick();
    sampleValid = 1'b0;
  endtask

  // Called in the trigger cycle; returns in the first IDLE cycle after the frame.
  task automatic run_frame(input logic [11:0] data, input logic exp_under, input logic exp_rdy1,
                           input bit trig_at5, input bit reset_at8);
    logic [15:0] frame;
    bit          saw_ldac;
    frame = {4'b0000, data};
    frameTrigger = 1'b1;
    #1;
    chk("underrun_trig", {15'd0, underrun}, {15'd0, exp_under});
    chk("busy_trig", {15'd0, busy}, 16'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      frameTrigger = (trig_at5 && i == 5);
      if (i == 2) sampleValid = 1'b0;
      if (reset_at8 && i == 8) reset = 1'b1;
      #1;
      if (reset_at8 && i == 9) begin
        chk("rst_sync", {15'd0, dacSync}, 16'd1);
        chk("rst_sdi", {15'd0, dacDataIn}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ready", {15'd0, sampleReady}, 16'd1);
        reset = 1'b0;
        saw_ldac = 1'b0;
        for (int k = 0; k < 20; k++) begin
          tick();
          if (ldac !== 1'b1) saw_ldac = 1'b1;
        end
        chk("rst_no_ldac", {15'd0, saw_ldac}, 16'd0);
        return;
      end
      chk("sync_low", {15'd0, dacSync}, 16'd0);
      chk("sdi_bit", {15'd0, dacDataIn}, {15'd0, frame[16-i]});
      chk("busy_shift", {15'd0, busy}, 16'd1);
      chk("ldac_shift", {15'd0, ldac}, 16'd1);
      if (i == 1) chk("ready_t1", {15'd0, sampleReady}, {15'd0, exp_rdy1});
      if (i == 5) chk("underrun_ign", {15'd0, underrun}, 16'd0);
    end
    tick();
    frameTrigger = 1'b0;
    #1;
    chk("sync_load", {15'd0, dacSync}, 16'd1);
    chk("sdi_load", {15'd0, dacDataIn}, 16'd0);
    chk("ldac_low", {15'd0, ldac}, 16'd0);
    chk("busy_load", {15'd0, busy}, 16'd1);
    tick();
    chk("ldac_high", {15'd0, ldac}, 16'd1);
    chk("busy_idle", {15'd0, busy}, 16'd0);
    chk("sync_idle", {15'd0, dacSync}, 16'd1);
  endtask

  initial begin
    reset        = 1'b1;
    frameTrigger = 1'b0;
    sampleValid  = 1'b0;
    sampleData   = 12'h000;
    tick();
    tick();
    chk("rst_sync", {15'd0, dacSync}, 16'd1);
    chk("rst_sdi", {15'd0, dacDataIn}, 16'd0);
    chk("rst_ldac", {15'd0, ldac}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_underrun", {15'd0, underrun}, 16'd0);
    chk("rst_ready", {15'd0, sampleReady}, 16'd1);
    reset = 1'b0;

    // 1: single sample frame
    load_sample(12'hA5C);
    chk("ready_full", {15'd0, sampleReady}, 16'd0);
    run_frame(exp_code(12'hA5C), 1'b0, 1'b1, 1'b0, 1'b0);

    // 2: repeat with underrun; accept in trigger cycle goes to next frame
    sampleValid = 1'b1;
    sampleData  = 12'h123;
    run_frame(exp_code(12'hA5C), 1'b1, 1'b0, 1'b0, 1'b0);

    // 3: hold full with valid held high; second sample accepted during SHIFT
    sampleValid = 1'b1;
    sampleData  = 12'h456;
    tick();
    chk("ready_blocked", {15'd0, sampleReady}, 16'd0);
    tick();
    run_frame(exp_code(12'h123), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ready_refilled", {15'd0, sampleReady}, 16'd0);

    // 4: mid-frame trigger ignored
    run_frame(exp_code(12'h456), 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ready_after_ign", {15'd0, sampleReady}, 16'd1);

    // 5: reset mid-frame, then underrun frame of zero
    run_frame(exp_code(12'h456), 1'b1, 1'b1, 1'b0, 1'b1);
    run_frame(12'h000, 1'b1, 1'b1, 1'b0, 1'b0);

    // 6: code-conversion boundaries
    load_sample(12'h800);
    run_frame(exp_code(12'h800), 1'b0, 1'b1, 1'b0, 1'b0);
    load_sample(12'h7FF);
    run_frame(exp_code(12'h7FF), 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
